// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with optional parity, mid-bit sampling and back-to-back frame support.
// Build option: define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around the sample point.
`timescale 1ns/1ps
module uart_rx #(
  parameter int OVS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX_IN,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  output logic [7:0] P_DATA,
  output logic       DATA_VALID,
  output logic       PAR_ERR,
  output logic       STP_ERR,
  output logic       Busy
);

  localparam int CW = $clog2(OVS);
`ifdef UART_RX_MAJORITY_EN
  localparam int DEC = OVS / 2 + 1;
`else
  localparam int DEC = OVS / 2;
`endif
  localparam logic [CW-1:0] DEC_PT = CW'(DEC);
  localparam logic [CW-1:0] LAST   = CW'(OVS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic logic parity_f(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  function automatic logic majority_f(input logic [2:0] s);
    return (s[0] & s[1]) | (s[1] & s[2]) | (s[0] & s[2]);
  endfunction

  state_t          state_r, state_nx_s;
  logic [1:0]      sync_r;
  logic            rxs_s, bit_s, dec_s, wrap_s;
  logic [CW-1:0]   cnt_r;
  logic [2:0]      idx_r;
  logic [7:0]      shift_r, p_data_r;
  logic            par_en_r, par_typ_r, par_bad_r;
  logic            dv_r, pe_r, se_r, busy_r;
  logic            dv_nx_s, pe_nx_s, se_nx_s;

  assign rxs_s  = sync_r[1];
  assign dec_s  = (cnt_r == DEC_PT);
  assign wrap_s = (cnt_r == LAST);

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_r;

  // history of the two previous synchronized samples for majority voting
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_r <= 2'b11;
    end else begin
      hist_r <= {hist_r[0], rxs_s};
    end
  end

  assign bit_s = majority_f({hist_r, rxs_s});
`else
  assign bit_s = rxs_s;
`endif

  // two-flop synchronizer, idles high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], RX_IN};
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // next-state and decision logic
  always_comb begin
    state_nx_s = state_r;
    dv_nx_s    = 1'b0;
    pe_nx_s    = 1'b0;
    se_nx_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (!rxs_s) state_nx_s = START;
        else        state_nx_s = IDLE;
      end
      START: begin
        if (dec_s && bit_s) state_nx_s = IDLE;
        else if (wrap_s)    state_nx_s = DATA;
        else                state_nx_s = START;
      end
      DATA: begin
        if (wrap_s && (idx_r == 3'd7)) state_nx_s = par_en_r ? PARITY : STOP;
        else                           state_nx_s = DATA;
      end
      PARITY: begin
        if (wrap_s) state_nx_s = STOP;
        else        state_nx_s = PARITY;
      end
      STOP: begin
        // decide mid-stop-bit so the next start edge is never missed
        if (dec_s) begin
          state_nx_s = IDLE;
          pe_nx_s    = par_bad_r;
          se_nx_s    = ~bit_s;
          dv_nx_s    = bit_s & ~par_bad_r;
        end else begin
          state_nx_s = STOP;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // bit counters, shift register, per-frame config latch and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r     <= '0;
      idx_r     <= 3'd0;
      shift_r   <= 8'h00;
      p_data_r  <= 8'h00;
      par_en_r  <= 1'b0;
      par_typ_r <= 1'b0;
      par_bad_r <= 1'b0;
      dv_r      <= 1'b0;
      pe_r      <= 1'b0;
      se_r      <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      dv_r   <= dv_nx_s;
      pe_r   <= pe_nx_s;
      se_r   <= se_nx_s;
      busy_r <= (state_nx_s != IDLE);
      if (dv_nx_s) p_data_r <= shift_r;
      if (state_r == IDLE) begin
        cnt_r <= '0;
        idx_r <= 3'd0;
        if (!rxs_s) begin
          par_en_r  <= PAR_EN;
          par_typ_r <= PAR_TYP;
          par_bad_r <= 1'b0;
        end
      end else begin
        cnt_r <= wrap_s ? '0 : cnt_r + CW'(1);
        if ((state_r == DATA) && dec_s)   shift_r   <= {bit_s, shift_r[7:1]};
        if ((state_r == DATA) && wrap_s)  idx_r     <= idx_r + 3'd1;
        if ((state_r == PARITY) && dec_s) par_bad_r <= (bit_s != parity_f(shift_r, par_typ_r));
      end
    end
  end

  assign P_DATA     = p_data_r;
  assign DATA_VALID = dv_r;
  assign PAR_ERR    = pe_r;
  assign STP_ERR    = se_r;
  assign Busy       = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx with OVS=8 (8-cycle bits driven on RX_IN).
`timescale 1ns/1ps
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n, RX_IN, PAR_EN, PAR_TYP;
  logic [7:0] P_DATA;
  logic       DATA_VALID, PAR_ERR, STP_ERR, Busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int dv_cnt = 0, pe_cnt = 0, se_cnt = 0, busy_cnt = 0, dv_cyc = 0;
  logic [7:0] dv_data = 8'h00;
  int busy0;

`ifdef UART_RX_MAJORITY_EN
  localparam int LAT = 81;
  localparam logic [7:0] MAJ_EXP = 8'h01;
`else
  localparam int LAT = 80;
  localparam logic [7:0] MAJ_EXP = 8'h00;
`endif

  uart_rx #(.OVS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RX_IN     (RX_IN),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_ERR   (PAR_ERR),
    .STP_ERR   (STP_ERR),
    .Busy      (Busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // pulse monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (DATA_VALID === 1'b1) begin
      dv_cnt  = dv_cnt + 1;
      dv_data = P_DATA;
      dv_cyc  = cyc;
    end
    if (PAR_ERR === 1'b1) pe_cnt = pe_cnt + 1;
    if (STP_ERR === 1'b1) se_cnt = se_cnt + 1;
    if (Busy === 1'b1) busy_cnt = busy_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    RX_IN = b;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic pbit,
                            input logic stopb, input logic flip);
    PAR_EN    = par;
    start_cyc = cyc;
    drive_bit(1'b0);
    if (flip) begin
      PAR_EN  = ~PAR_EN;
      PAR_TYP = ~PAR_TYP;
    end
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (par) drive_bit(pbit);
    drive_bit(stopb);
    if (flip) begin
      PAR_EN  = ~PAR_EN;
      PAR_TYP = ~PAR_TYP;
    end
  endtask

  initial begin
    rst_n = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pdata", P_DATA, 8'h00);
    chk("rst_dv", DATA_VALID, 1'b0);
    chk("rst_pe", PAR_ERR, 1'b0);
    chk("rst_se", STP_ERR, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    rst_n = 1'b1;
    idle(4);

    // 0xA5, no parity
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(16);
    chk("a5_dvcnt", dv_cnt, 1);
    chk("a5_dvdata", dv_data, 8'hA5);
    chk("a5_pdata", P_DATA, 8'hA5);
    chk("a5_pe", pe_cnt, 0);
    chk("a5_se", se_cnt, 0);
    chk("a5_busy", Busy, 1'b0);
    chk("a5_latency", dv_cyc - start_cyc, LAT);

    // 0x4D odd parity, correct parity bit
    PAR_TYP = 1'b1;
    send_frame(8'h4D, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(16);
    chk("4d_dvcnt", dv_cnt, 2);
    chk("4d_pdata", P_DATA, 8'h4D);
    chk("4d_pe", pe_cnt, 0);

    // 0x4D wrong parity bit; config toggled mid-frame must be ignored
    send_frame(8'h4D, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(16);
    chk("4dbad_pe", pe_cnt, 1);
    chk("4dbad_se", se_cnt, 0);
    chk("4dbad_dvcnt", dv_cnt, 2);
    chk("4dbad_pdata", P_DATA, 8'h4D);

    // 0x3C with stop 0, then 0x81 back-to-back
    PAR_TYP = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(16);
    chk("3c_se", se_cnt, 1);
    chk("3c_pe", pe_cnt, 1);
    chk("81_dvcnt", dv_cnt, 3);
    chk("81_pdata", P_DATA, 8'h81);

    // 2-cycle glitch on idle line
    busy0 = busy_cnt;
    RX_IN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle(20);
    chk("glitch_busy_pulsed", ((busy_cnt - busy0) > 0) && ((busy_cnt - busy0) <= 8), 1'b1);
    chk("glitch_busy_end", Busy, 1'b0);
    chk("glitch_dvcnt", dv_cnt, 3);
    chk("glitch_flags", pe_cnt + se_cnt, 2);

    // reset pulse during data bit 4 of 0xFF
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    RX_IN = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    idle(16);
    chk("rstmid_pdata", P_DATA, 8'h00);
    chk("rstmid_dvcnt", dv_cnt, 3);
    chk("rstmid_flags", pe_cnt + se_cnt, 2);
    chk("rstmid_busy", Busy, 1'b0);

    send_frame(8'h12, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(16);
    chk("12_dvcnt", dv_cnt, 4);
    chk("12_pdata", P_DATA, 8'h12);

    // 0x01 with a 1-cycle low at the sample point of data bit 0
    drive_bit(1'b0);
    RX_IN = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    RX_IN = 1'b0;
    @(posedge clk);
    #1;
    RX_IN = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 1; i < 8; i++) drive_bit(1'b0);
    drive_bit(1'b1);
    idle(16);
    chk("maj_dvcnt", dv_cnt, 5);
    chk("maj_pdata", P_DATA, MAJ_EXP);
    chk("maj_flags", pe_cnt + se_cnt, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
